// File: rtl/regfile_sched_pkg.sv
// Shared types and helpers for the register-file write scheduler.
package regfile_sched_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } sched_state_t;

  // Widest requester vector the rotate helpers handle.
  localparam int unsigned max_req = 8;

  // Rotate the low n bits of v right by sh: result bit i comes from bit (i+sh) mod n.
  function automatic logic [max_req-1:0] rot_right(input logic [max_req-1:0] v,
                                                   input int unsigned     sh,
                                                   input int unsigned     n);
    logic [max_req-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < max_req; i++) begin
      if (i < n) r[i] = v[(i + sh) % n];
    end
    return r;
  endfunction

  // Inverse of rot_right: bit i moves to bit (i+sh) mod n.
  function automatic logic [max_req-1:0] rot_left(input logic [max_req-1:0] v,
                                                  input int unsigned     sh,
                                                  input int unsigned     n);
    logic [max_req-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < max_req; i++) begin
      if (i < n) r[(i + sh) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter; priority starts at ptr and wraps.
module rr_arbiter
  import regfile_sched_pkg::*;
#(
  parameter int unsigned n = 4,
  localparam int unsigned pw = $clog2(n)
) (
  input  logic [n-1:0]  req,
  input  logic [pw-1:0] ptr,
  input  logic          en,
  output logic [n-1:0]  gnt,
  output logic [pw-1:0] gnt_idx
);

  logic [max_req-1:0] req_w;
  logic [max_req-1:0] rot;
  logic [max_req-1:0] pick;
  logic [max_req-1:0] back;
  logic               found;

  // Rotate so ptr sits at bit 0, take the lowest request, rotate back.
  always_comb begin
    req_w          = '0;
    req_w[n-1:0]   = req;
    rot            = rot_right(req_w, ptr, n);
    pick           = '0;
    found          = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    back    = rot_left(pick, ptr, n);
    gnt     = en ? back[n-1:0] : '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (gnt[i]) gnt_idx = pw'(i);
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler: round-robin sharing of the register file write port
// plus a lo..hi clear sequencer. All write-side outputs are registered.
module regfile_wr_sched
  import regfile_sched_pkg::*;
#(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 64,
  parameter int unsigned lo         = 0,
  parameter int unsigned hi         = 31,
  parameter int unsigned num_req    = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [num_req-1:0]               REQ_VALID,
  input  logic [num_req*addr_width-1:0]    REQ_ADDR,
  input  logic [num_req*data_width-1:0]    REQ_DATA,
  output logic [num_req-1:0]               REQ_READY,
  input  logic                             CLR_START,
  input  logic [data_width-1:0]            CLR_DATA,
  output logic                             CLR_BUSY,
  output logic                             CLR_DONE,
  output logic                             ERR,
  output logic                             WE,
  output logic [addr_width-1:0]            ADDR_IN,
  output logic [data_width-1:0]            D_IN
);

  localparam int unsigned pw = $clog2(num_req);

  localparam logic [addr_width-1:0] lo_a   = addr_width'(lo);
  localparam logic [addr_width-1:0] hi_a   = addr_width'(hi);
  localparam logic [addr_width:0]   lo_x   = (addr_width + 1)'(lo);
  localparam logic [addr_width:0]   span_x = (addr_width + 1)'(hi - lo);

  sched_state_t              state, state_n;
  logic [addr_width-1:0]     cnt, cnt_n;
  logic [data_width-1:0]     fill, fill_n;
  logic [pw-1:0]             rr_ptr, ptr_n;

  logic                      we_n;
  logic [addr_width-1:0]     addr_n;
  logic [data_width-1:0]     d_n;
  logic                      busy_n;
  logic                      done_n;
  logic                      err_n;

  logic                      arb_en;
  logic [num_req-1:0]        gnt;
  logic [pw-1:0]             gnt_idx;
  logic [addr_width-1:0]     sel_addr;
  logic [data_width-1:0]     sel_data;
  logic [addr_width:0]       addr_off;
  logic                      in_range;

  // Grants only in IDLE when no clear is starting; forced off during reset.
  always_comb begin
    arb_en = (state == IDLE) && !CLR_START && !RST;
  end

  rr_arbiter #(
    .n (num_req)
  ) u_arb (
    .req     (REQ_VALID),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Select the granted requester's payload and range-check its address.
  always_comb begin
    REQ_READY = gnt;
    sel_addr  = REQ_ADDR[gnt_idx*addr_width +: addr_width];
    sel_data  = REQ_DATA[gnt_idx*data_width +: data_width];
    // Offset from lo in one extra bit: below-lo addresses wrap above span.
    addr_off  = {1'b0, sel_addr} - lo_x;
    in_range  = (addr_off <= span_x);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fill_n  = fill;
    ptr_n   = rr_ptr;
    we_n    = 1'b0;
    addr_n  = ADDR_IN;
    d_n     = D_IN;
    busy_n  = CLR_BUSY;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (CLR_START) begin
          state_n = CLEAR;
          cnt_n   = lo_a;
          fill_n  = CLR_DATA;
          busy_n  = 1'b1;
        end else if (|gnt) begin
          ptr_n = (gnt_idx == pw'(num_req - 1)) ? '0 : gnt_idx + 1'b1;
          if (in_range) begin
            we_n   = 1'b1;
            addr_n = sel_addr;
            d_n    = sel_data;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      CLEAR: begin
        we_n   = 1'b1;
        addr_n = cnt;
        d_n    = fill;
        if (cnt == hi_a) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= lo_a;
      fill     <= '0;
      rr_ptr   <= '0;
      WE       <= 1'b0;
      ADDR_IN  <= '0;
      D_IN     <= '0;
      CLR_BUSY <= 1'b0;
      CLR_DONE <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      fill     <= fill_n;
      rr_ptr   <= ptr_n;
      WE       <= we_n;
      ADDR_IN  <= addr_n;
      D_IN     <= d_n;
      CLR_BUSY <= busy_n;
      CLR_DONE <= done_n;
      ERR      <= err_n;
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomized bench for regfile_wr_sched against a queue-based reference model.
module tb_regfile_wr_sched;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int LO = 3;
  localparam int HI = 28;
  localparam int N  = 4;

  logic            CLK;
  logic            RST;
  logic [N-1:0]    REQ_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic            CLR_START;
  logic [DW-1:0]   CLR_DATA;
  logic            CLR_BUSY;
  logic            CLR_DONE;
  logic            ERR;
  logic            WE;
  logic [AW-1:0]   ADDR_IN;
  logic [DW-1:0]   D_IN;

  regfile_wr_sched #(
    .addr_width (AW),
    .data_width (DW),
    .lo         (LO),
    .hi         (HI),
    .num_req    (N)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .CLR_START (CLR_START),
    .CLR_DATA  (CLR_DATA),
    .CLR_BUSY  (CLR_BUSY),
    .CLR_DONE  (CLR_DONE),
    .ERR       (ERR),
    .WE        (WE),
    .ADDR_IN   (ADDR_IN),
    .D_IN      (D_IN)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int            m_ptr = 0;
  bit            m_clr = 0;
  logic [DW-1:0] m_fill = '0;
  int            clr_q[$];

  // Expected registered outputs after the upcoming edge.
  logic          exp_we   = 1'b0;
  int            exp_addr = 0;
  logic [DW-1:0] exp_d    = '0;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_err  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check grant, advance model.
  task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d, input bit cs, input logic [DW-1:0] cd);
    int g;
    int ga;
    logic [N-1:0] exp_ready;
    @(negedge CLK);
    check("WE", WE, exp_we);
    check("ADDR_IN", ADDR_IN, exp_addr);
    check("D_IN", D_IN, exp_d);
    check("CLR_BUSY", CLR_BUSY, exp_busy);
    check("CLR_DONE", CLR_DONE, exp_done);
    check("ERR", ERR, exp_err);
    RST       = rst;
    REQ_VALID = v;
    REQ_ADDR  = a;
    REQ_DATA  = d;
    CLR_START = cs;
    CLR_DATA  = cd;
    #1;
    g = -1;
    exp_ready = '0;
    if (!rst && !m_clr && !cs) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("REQ_READY", REQ_READY, exp_ready);
    if (rst) begin
      check("WE_async_rst", WE, 1'b0);
      check("BUSY_async_rst", CLR_BUSY, 1'b0);
      m_ptr = 0;
      m_clr = 0;
      clr_q.delete();
      exp_we = 0; exp_addr = 0; exp_d = '0;
      exp_busy = 0; exp_done = 0; exp_err = 0;
    end else if (m_clr) begin
      exp_we   = 1'b1;
      exp_addr = clr_q.pop_front();
      exp_d    = m_fill;
      exp_err  = 1'b0;
      exp_done = (clr_q.size() == 0);
      exp_busy = !exp_done;
      m_clr    = !exp_done;
    end else if (cs) begin
      m_clr  = 1;
      m_fill = cd;
      for (int x = LO; x <= HI; x++) clr_q.push_back(x);
      exp_we = 0; exp_busy = 1; exp_done = 0; exp_err = 0;
    end else if (g >= 0) begin
      ga    = int'(a[g*AW +: AW]);
      m_ptr = (g + 1) % N;
      exp_done = 0;
      if (ga >= LO && ga <= HI) begin
        exp_we = 1; exp_addr = ga; exp_d = d[g*DW +: DW]; exp_err = 0;
      end else begin
        exp_we = 0; exp_err = 1;
      end
    end else begin
      exp_we = 0; exp_err = 0; exp_done = 0;
    end
  endtask

  function automatic logic [N*AW-1:0] rand_addrs(input int lo_a, input int hi_a);
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom_range(hi_a, lo_a));
    return r;
  endfunction

  function automatic logic [N*DW-1:0] rand_datas();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = {$urandom, $urandom};
    return r;
  endfunction

  logic [N*AW-1:0] ad;
  logic [N*DW-1:0] dd;

  initial begin
    RST = 1'b0; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0;
    CLR_START = 1'b0; CLR_DATA = '0;
    #1 RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Single request from requester 1.
    ad = '0; dd = '0;
    ad[1*AW +: AW] = AW'(7);
    dd[1*DW +: DW] = 64'hA5;
    step(0, 4'b0010, ad, dd, 0, '0);
    step(0, 4'b0000, ad, dd, 0, '0);
    step(0, 4'b0000, ad, dd, 0, '0);

    // Fairness from reset with all requesters pending.
    step(1, '0, '0, '0, 0, '0);
    for (int i = 0; i < 8; i++) step(0, 4'b1111, rand_addrs(LO, HI), rand_datas(), 0, '0);

    // Out-of-range requests, above and below the window.
    ad = '0;
    ad[1*AW +: AW] = AW'(30);
    step(0, 4'b0010, ad, rand_datas(), 0, '0);
    ad[1*AW +: AW] = AW'(1);
    step(0, 4'b0010, ad, rand_datas(), 0, '0);
    step(0, 4'b0000, ad, rand_datas(), 0, '0);

    // Clear while all requests pending, with a second CLR_START mid-sequence.
    step(0, 4'b1111, rand_addrs(LO, HI), rand_datas(), 1, {$urandom, $urandom});
    for (int i = 0; i < HI - LO + 6; i++)
      step(0, 4'b1111, rand_addrs(LO, HI), rand_datas(), (i == 7), {$urandom, $urandom});

    // Reset in the middle of a clear.
    step(0, 4'b0101, rand_addrs(LO, HI), rand_datas(), 1, 64'h0);
    for (int i = 0; i < 8; i++) step(0, 4'b0101, rand_addrs(LO, HI), rand_datas(), 0, '0);
    step(1, 4'b0101, rand_addrs(LO, HI), rand_datas(), 0, '0);
    for (int i = 0; i < 4; i++) step(0, 4'b0000, '0, '0, 0, '0);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(199, 0) == 0), N'($urandom), rand_addrs(0, 31), rand_datas(),
           ($urandom_range(39, 0) == 0), {$urandom, $urandom});
    end
    step(0, '0, '0, '0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
